// File: rtl/imem_port_sequencer.sv
// Single-port sequencer for a byte-wide instruction memory: round-robin sharing between
// fetch and loader, four big-endian byte accesses per word, range/alignment screening.
module imem_port_sequencer #(
    parameter int unsigned MEM_SIZE = 4095,
    parameter int unsigned ADDR_W   = 64
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_ready_o,
    output logic              fetch_valid_o,
    output logic [31:0]       fetch_instr_o,
    output logic              fetch_fault_o,
    input  logic              load_req_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_SIZE - 32'd4);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_DRAIN, S_RESP, S_WR, S_WDONE, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wword_q, wword_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       instr_q, instr_d;
    logic              last_load_q, last_load_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              grant_fetch_s, grant_load_s;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            2'd3:    return w[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r = w;
        endcase
        return r;
    endfunction

    // Full-width compare so addresses near the top of the bus never wrap into range.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_WORD);
    endfunction

    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] b, input logic [1:0] k);
        return b + {{(ADDR_W-2){1'b0}}, k};
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant_fetch_s = 1'b0;
        grant_load_s  = 1'b0;
        if (reset_ni && (state_q == S_IDLE)) begin
            grant_fetch_s = fetch_req_i && (!load_req_i || last_load_q);
            grant_load_s  = load_req_i && !grant_fetch_s;
        end else begin
            grant_fetch_s = 1'b0;
            grant_load_s  = 1'b0;
        end
    end

    assign fetch_ready_o = grant_fetch_s;
    assign load_ready_o  = grant_load_s;

    // Next-state and next-output logic; memory strobes are precomputed one cycle ahead.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        base_d        = base_q;
        wword_d       = wword_q;
        asm_d         = asm_q;
        instr_d       = instr_q;
        last_load_d   = last_load_q;
        fetch_valid_d = 1'b0;
        fetch_fault_d = 1'b0;
        load_done_d   = 1'b0;
        load_err_d    = 1'b0;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_fetch_s) begin
                    last_load_d = 1'b0;
                    if (addr_bad(fetch_addr_i)) begin
                        state_d       = S_FAULT;
                        fetch_valid_d = 1'b1;
                        fetch_fault_d = 1'b1;
                        instr_d       = 32'h0000_0000;
                    end else begin
                        state_d    = S_RD;
                        k_d        = 2'd0;
                        base_d     = fetch_addr_i;
                        mem_en_d   = 1'b1;
                        mem_addr_d = fetch_addr_i;
                    end
                end else if (grant_load_s) begin
                    last_load_d = 1'b1;
                    if (addr_bad(load_addr_i)) begin
                        state_d     = S_FAULT;
                        load_done_d = 1'b1;
                        load_err_d  = 1'b1;
                    end else begin
                        state_d     = S_WR;
                        k_d         = 2'd0;
                        base_d      = load_addr_i;
                        wword_d     = load_data_i;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = load_addr_i;
                        mem_wdata_d = word_byte(load_data_i, 2'd0);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                // Read data lags the strobe by one cycle, so lane k-1 lands here.
                if (k_q != 2'd0) begin
                    asm_d = put_byte(asm_q, k_q - 2'd1, mem_rdata_i);
                end else begin
                    asm_d = asm_q;
                end
                if (k_q == 2'd3) begin
                    state_d = S_RD_DRAIN;
                end else begin
                    k_d        = k_q + 2'd1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = lane_addr(base_q, k_q + 2'd1);
                end
            end
            S_RD_DRAIN: begin
                asm_d         = put_byte(asm_q, 2'd3, mem_rdata_i);
                instr_d       = {asm_q[31:8], mem_rdata_i};
                fetch_valid_d = 1'b1;
                state_d       = S_RESP;
            end
            S_WR: begin
                if (k_q == 2'd3) begin
                    state_d     = S_WDONE;
                    load_done_d = 1'b1;
                end else begin
                    k_d         = k_q + 2'd1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = lane_addr(base_q, k_q + 2'd1);
                    mem_wdata_d = word_byte(wword_q, k_q + 2'd1);
                end
            end
            S_RESP, S_WDONE, S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= S_IDLE;
            k_q           <= 2'd0;
            base_q        <= '0;
            wword_q       <= 32'h0000_0000;
            asm_q         <= 32'h0000_0000;
            instr_q       <= 32'h0000_0000;
            last_load_q   <= 1'b1;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            base_q        <= base_d;
            wword_q       <= wword_d;
            asm_q         <= asm_d;
            instr_q       <= instr_d;
            last_load_q   <= last_load_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            load_done_q   <= load_done_d;
            load_err_q    <= load_err_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign fetch_valid_o = fetch_valid_q;
    assign fetch_fault_o = fetch_fault_q;
    assign fetch_instr_o = instr_q;
    assign load_done_o   = load_done_q;
    assign load_err_o    = load_err_q;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: doc/imem_port_sequencer.md
Name: imem_port_sequencer

Overview:
- Single-port controller for the byte-wide instruction memory.
- Shares the one memory port between the pipeline fetch requester and the program loader (testbench or boot loader write port), with round-robin arbitration.
- Sequences four byte accesses per 32-bit word, big-endian: byte at addr+0 is bits [31:24].
- Assembles fetched words, scatters loader words, and flags out-of-range or misaligned requests without touching memory.

Parameters:
- MEM_SIZE, 4095: number of bytes in the memory array. The valid byte range is 0..MEM_SIZE-1.
- ADDR_W, 64: width of the requester and memory address buses.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- fetch_req  in  1  Fetch request. Held high, with fetch_addr stable, until fetch_ready.
- fetch_addr  in  ADDR_W  Byte address of the instruction.
- fetch_ready  out  1  Fetch accepted this cycle (combinational; IDLE only).
- fetch_valid  out  1  One-cycle pulse: fetch_instr / fetch_fault valid.
- fetch_instr  out  32  Assembled instruction. Held until the next fetch completes.
- fetch_fault  out  1  Qualified by fetch_valid. Indicates a misaligned or out-of-range fetch.
- load_req  in  1  Loader write request. Held high until load_ready.
- load_addr  in  ADDR_W  Byte address of the word to write.
- load_data  in  32  Word to write, big-endian.
- load_ready  out  1  Load accepted this cycle (combinational; IDLE only).
- load_done  out  1  One-cycle pulse: load finished.
- load_err  out  1  Qualified by load_done. Indicates the load was rejected and no bytes were written.
- mem_en  out  1  Memory access strobe.
- mem_we  out  1  Write enable. Only meaningful when mem_en=1.
- mem_addr  out  ADDR_W  Byte address presented to the memory.
- mem_wdata  out  8  Write byte.
- mem_rdata  in  8  Read byte. Synchronous memory: valid in the cycle after an mem_en=1, mem_we=0 cycle.

Behaviour:
- Reset (low, asynchronous):
  - state=IDLE.
  - All outputs 0, including fetch_instr=0, mem_en=0 and mem_addr=0.
  - last_grant=LOAD, so fetch wins the first contention.
  - Reset mid-operation abandons the sequence immediately. A partially written word stays partially written; no done/valid pulse is issued.
- States: IDLE, RD (4 cycles, k=0..3), RD_DRAIN (1), RESP (1), WR (4 cycles, k=0..3), WDONE (1), FAULT (1).
- Arbitration (IDLE only):
  - If only one request is high, it is granted.
  - If both are high, grant the requester not granted last; update last_grant on every grant.
  - ready is never asserted outside IDLE.
- Address check at grant, with cycle T the grant cycle:
  - Fault if addr[1:0]!=0, or if addr > MEM_SIZE-4 (compare at full ADDR_W width, no wrap).
  - Faulted fetch: FAULT at T+1 with fetch_valid=1, fetch_fault=1, fetch_instr=0. There is no mem_en.
  - Faulted load: load_done=1, load_err=1 at T+1. There is no mem_en.
- Fetch timing:
  - Address latched at T.
  - RD cycles T+1..T+4 drive mem_en=1, mem_we=0, mem_addr=base+k.
  - mem_rdata is captured at T+2..T+5 into byte lane [31-8k:24-8k]; RD_DRAIN at T+5 captures the last byte.
  - RESP at T+6: fetch_valid=1, fetch_fault=0, fetch_instr holds the full word. Latency from grant is 6 cycles.
- Load timing:
  - Address and data latched at T.
  - WR cycles T+1..T+4 drive mem_en=1, mem_we=1, mem_addr=base+k, mem_wdata=data[31-8k:24-8k].
  - WDONE at T+5: load_done=1, load_err=0.
- Return and idle outputs:
  - RESP, WDONE and FAULT return to IDLE the next cycle. A new grant is possible in that IDLE cycle, giving back-to-back throughput of one word per 7 cycles (read) or 6 (write).
  - mem_en=0 in IDLE, RD_DRAIN, RESP, WDONE and FAULT.
  - mem_addr and mem_wdata hold their last value when mem_en=0.
- Protocol rules:
  - A request dropped before ready is ignored (no state change).
  - fetch_valid and load_done never assert in the same cycle.
  - mem_we=1 never coincides with a fetch sequence.

Test Plan:
- Reset, then a loader write of 0xDEADBEEF at addr 0x10 -> mem bytes 0x10..0x13 = DE,AD,BE,EF written T+1..T+4; load_done=1, load_err=0 at T+5.
- Fetch at 0x10 after that load -> mem_addr 0x10..0x13 at T+1..T+4; fetch_valid=1 at T+6 with fetch_instr=0xDEADBEEF, fetch_fault=0.
- fetch_req and load_req both held from reset release -> fetch granted first. Load is granted in the IDLE after fetch RESP. On the next simultaneous request, fetch is granted again after the load.
- Fetch at 0x12 (misaligned), and fetch at MEM_SIZE-3 = 4092 -> FAULT at T+1: fetch_valid=1, fetch_fault=1, fetch_instr=0, mem_en=0 throughout. Load at 4092 -> load_done=1, load_err=1, no write.
- Boundary fetch at addr 4088 (=MEM_SIZE-7, aligned, last byte 4091) -> accepted, fault=0. Fetch at 0xFFFF_FFFF_FFFF_FFFC -> fault (no wrap).
- Reset asserted low at WR k=2 -> mem_en=0 and all outputs 0 in the same cycle, no load_done. After release, fetch_ready is available in the first IDLE cycle, and bytes base+2 and base+3 are not written.
